// File: rtl/sample_ctrl_pkg.sv
// Shared types and default sizing for the sample controller slice.
package sample_ctrl_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int NREQ_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/sample_ctrl_rr_arb.sv
// Round-robin arbiter: picks the lowest requesting index above ptr, wrapping.
module rr_arb #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // k walks the rotation distance from ptr, so the first hit is the winner.
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!any && req[i] && (i == ((int'(ptr) + k) % NREQ))) begin
          any    = 1'b1;
          gnt[i] = 1'b1;
          idx    = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/sample_ctrl.sv
// Free-running counter with round-robin arbitrated snapshot capture on even counts.
module sample_ctrl
  import sample_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_en,
  input  logic             cnt_clr,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  ack,
  output logic [WIDTH-1:0] snap_data,
  output logic [WIDTH-1:0] count,
  output logic             busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state, state_nxt;
  logic [NREQ-1:0] win_oh, win_oh_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic            capture;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      win_oh <= '0;
      ptr    <= IW'(NREQ - 1);
    end else begin
      state  <= state_nxt;
      win_oh <= win_oh_nxt;
      ptr    <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    win_oh_nxt = win_oh;
    ptr_nxt    = ptr;
    capture    = 1'b0;
    ack        = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        // The pointer moves on arbitration, so an aborted grant still rotates priority.
        if (arb_any) begin
          state_nxt  = GRANT;
          win_oh_nxt = arb_gnt;
          ptr_nxt    = arb_idx;
        end
      end
      GRANT: begin
        if ((req & win_oh) == '0) begin
          state_nxt = IDLE;
        end else if (!count[0]) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        ack       = win_oh;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter runs independently of the FSM; capture sees the pre-update value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      snap_data <= '0;
    end else begin
      if (cnt_clr)     count <= '0;
      else if (cnt_en) count <= count + 1'b1;
      if (capture)     snap_data <= count;
    end
  end

endmodule

// File: tb/tb_sample_ctrl.sv
// Randomized and directed bench for sample_ctrl against a transaction-level model.
module tb_sample_ctrl;

  localparam int W = 8;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cnt_en = 1'b0;
  logic         cnt_clr = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] ack;
  logic [W-1:0] snap_data;
  logic [W-1:0] count;
  logic         busy;

  int checks = 0;
  int errors = 0;

  sample_ctrl #(.WIDTH(W), .NREQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .req       (req),
    .ack       (ack),
    .snap_data (snap_data),
    .count     (count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Transaction model: counter value, last snapshot, open transaction and its winner.
  int m_cnt, m_snap, m_last, m_w;
  bit m_act, m_resp, model_ok;

  always @(posedge clk) begin
    int c, rq, j;
    bit found;
    if (!rst_n) begin
      m_cnt = 0; m_snap = 0; m_act = 0; m_resp = 0; m_last = N - 1; m_w = 0;
      model_ok = 1;
    end else begin
      c  = m_cnt;
      rq = int'(req);
      if (m_resp) begin
        m_resp = 0; m_act = 0;
      end else if (m_act) begin
        if (((rq >> m_w) & 1) == 0) m_act = 0;
        else if (c % 2 == 0) begin m_snap = c; m_resp = 1; end
      end else if (rq != 0) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          j = (m_last + k) % N;
          if (!found && ((rq >> j) & 1) != 0) begin
            found = 1; m_w = j; m_last = j; m_act = 1;
          end
        end
      end
      if (cnt_clr)     m_cnt = 0;
      else if (cnt_en) m_cnt = (m_cnt + 1) % (1 << W);
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_count", count, m_cnt);
      chk("m_snap", snap_data, m_snap);
      chk("m_ack", ack, m_resp ? (1 << m_w) : 0);
      chk("m_busy", busy, m_act);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic [N-1:0] exp, input string nm, output int waited);
    waited = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      waited++;
      if (ack != '0) break;
    end
    chk(nm, ack, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cnt_en = 1'b0; cnt_clr = 1'b0; req = '0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int lat, nacks;
    logic [N-1:0] prev;

    repeat (2) cyc();
    chk("rst_count", count, 0);
    chk("rst_snap", snap_data, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);

    // Five enabled cycles, then a single requester with an odd count.
    rst_n = 1'b1; cnt_en = 1'b1;
    repeat (5) cyc();
    chk("cnt5_count", count, 5);
    chk("cnt5_snap", snap_data, 0);
    chk("cnt5_ack", ack, 0);
    req = 2'b01;
    wait_ack(2'b01, "req01_ack", lat);
    chk("req01_lat", lat, 2);
    chk("req01_snap", snap_data, 6);
    chk("req01_even", snap_data[0], 0);
    req = '0;
    cyc();
    chk("req01_ack_once", ack, 0);

    // Both requesters held: grants must alternate, starting with req[0].
    do_reset();
    req = 2'b11; cnt_en = 1'b1;
    prev = '0; nacks = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      chk("rr_onehot", (ack == 2'b11), 0);
      if (ack != '0) begin
        chk("rr_alt", ack, (prev == '0) ? 2'b01 : (prev ^ 2'b11));
        prev = ack;
        nacks++;
      end
    end
    chk("rr_nacks", (nacks >= 8), 1);

    // Stalled at an odd count: waits indefinitely until a clear makes it even.
    do_reset();
    cnt_en = 1'b1;
    repeat (7) cyc();
    chk("stall_count", count, 7);
    cnt_en = 1'b0; req = 2'b10;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("stall_busy", busy, 1);
      chk("stall_ack", ack, 0);
    end
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    wait_ack(2'b10, "clr_ack", lat);
    chk("clr_snap", snap_data, 0);
    req = '0;
    cyc();

    // Wrap of the counter with a snapshot taken across it.
    do_reset();
    cnt_en = 1'b1;
    repeat (254) cyc();
    chk("wrap_fe", count, 8'hFE);
    req = 2'b01;
    cyc();
    chk("wrap_ff", count, 8'hFF);
    cyc();
    chk("wrap_00", count, 0);
    wait_ack(2'b01, "wrap_ack", lat);
    chk("wrap_snap", (snap_data == 8'hFE || snap_data == 8'h00), 1);
    req = '0;
    cyc();

    // Request withdrawn while waiting, then reset asserted during the response.
    do_reset();
    cnt_en = 1'b1;
    cyc();
    cnt_en = 1'b0; req = 2'b01;
    cyc();
    cyc();
    chk("drop_busy_pre", busy, 1);
    req = '0;
    cyc();
    chk("drop_busy", busy, 0);
    chk("drop_ack", ack, 0);
    cyc();
    chk("drop_ack2", ack, 0);
    cnt_en = 1'b1;
    cyc();
    cnt_en = 1'b0; req = 2'b01;
    cyc();
    cyc();
    chk("resp_ack", ack, 2'b01);
    chk("resp_snap", snap_data, 2);
    rst_n = 1'b0;
    cyc();
    chk("rstresp_ack", ack, 0);
    chk("rstresp_busy", busy, 0);
    chk("rstresp_count", count, 0);
    chk("rstresp_snap", snap_data, 0);
    rst_n = 1'b1; req = '0;

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      cnt_en  = ($urandom_range(0, 9) < 7);
      cnt_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) < 3) req = N'($urandom_range(0, (1 << N) - 1));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_ctrl.md
SAMPLE_CTRL -- requirements
Module: sample_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: counter and snapshot width.
REQ-002 The block SHALL have parameter NREQ, default 2: number of snapshot requesters.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-004 Port: clk  input  1  sole clock, all state on posedge.
REQ-005 Port: rst_n  input  1  synchronous active-low reset.
REQ-006 Port: cnt_en  input  1  counter increment enable.
REQ-007 Port: cnt_clr  input  1  synchronous counter clear.
REQ-008 Port: req  input  NREQ  per-requester snapshot request, level.
REQ-009 Port: ack  output  NREQ  per-requester one-cycle snapshot-valid pulse.
REQ-010 Port: snap_data  output  WIDTH  last captured counter value.
REQ-011 Port: count  output  WIDTH  live counter value.
REQ-012 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-013 count SHALL become 0 when cnt_clr=1, else count+1 mod 2^WIDTH when cnt_en=1, else hold; cnt_clr has priority over cnt_en.
REQ-014 count SHALL wrap from 2^WIDTH-1 to 0 without flag or stall.
REQ-015 FSM states SHALL be IDLE, GRANT, RESP.
REQ-016 IDLE SHALL go to GRANT on any req bit set, latching the winner index chosen by round-robin.
REQ-017 Round-robin SHALL favour the lowest index above the previous winner, wrapping; after reset req[0] has highest priority.
REQ-018 In GRANT, capture SHALL occur on an edge where count[0]==0 (pre-update value): snap_data<=count, next state RESP.
REQ-019 In GRANT with count[0]==1, the FSM SHALL stay in GRANT (even-only capture rule); with cnt_en=0 and cnt_clr=0 it waits indefinitely.
REQ-020 In GRANT, if the winner's req is low, the FSM SHALL return to IDLE with no capture and no ack; round-robin pointer still advances.
REQ-021 In RESP, ack[winner] SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-022 At most one ack bit SHALL be high in any cycle; ack SHALL be 0 outside RESP.
REQ-023 snap_data SHALL hold its value between captures.
REQ-024 Latency: req rising in IDLE at cycle 0 with count even at cycle 1 -> ack high in cycle 2.
REQ-025 A requester holding req after ack SHALL be re-arbitrated from IDLE the following cycle, behind any other pending requester.
REQ-026 Counter updates SHALL continue unaffected by FSM state.

Reset
REQ-027 On rst_n=0 at posedge: count=0, snap_data=0, ack=0, busy=0, state=IDLE, round-robin pointer=NREQ-1.
REQ-028 Reset mid-transaction SHALL abort without ack; reset SHALL override cnt_clr, cnt_en and req.

Structure
REQ-029 Package sample_ctrl_pkg SHALL hold the FSM state enum and WIDTH/NREQ defaults.
REQ-030 Round-robin arbitration SHALL be a sub-module rr_arb (req vector, pointer -> one-hot grant and index).

Verification
REQ-031 Reset then cnt_en=1 for 5 cycles -> count=5, snap_data=0, ack=0.
REQ-032 count=4, req=01 held -> GRANT next cycle, capture 5? no: capture occurs only at even count; bench SHALL check snap_data even and ack=01 for one cycle.
REQ-033 req=11 held continuously from reset, cnt_en=1 -> acks alternate 01,10,01,10; no cycle with both bits set.
REQ-034 cnt_en=0, count=7, req=10 -> busy stays 1, no ack for 20 cycles; pulse cnt_clr -> snap_data=0, ack=10.
REQ-035 count=0xFFFFFFFE, cnt_en=1 -> count 0xFFFFFFFF then 0; snapshot requested there returns 0xFFFFFFFE or 0.
REQ-036 req=01 dropped while in GRANT with count odd -> IDLE, no ack; rst_n=0 asserted in RESP -> ack=0 next cycle, all outputs 0.
